// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encoding, frame bit indices and parity helper
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        XFER,
        ACK,
        WAIT_IDLE
    } ps2_state_t;

    localparam logic [3:0] PARITY_BIT = 4'd9;
    localparam logic [3:0] STOP_BIT   = 4'd10;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchroniser, stability filter and falling-edge pulse for one PS/2 line
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic sync,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          meta;
    logic [CW-1:0] cnt;

    // Lines idle high, so the synchroniser and filter start high to avoid a spurious fall after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta  <= 1'b1;
            sync  <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            fall  <= 1'b0;
        end else begin
            meta <= raw;
            sync <= meta;
            fall <= 1'b0;
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                level <= sync;
                cnt   <= '0;
                fall  <= level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter driving open-drain output enables
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] din,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int IW = $clog2(INHIBIT_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    ps2_state_t    state, nxt;
    logic [IW-1:0] ic;
    logic [TW-1:0] tmo;
    logic [3:0]    cnt;
    logic [8:0]    sh;
    logic          tx;
    logic          set_done, set_err, timed, expire;
    logic          clk_sync, fall, data_sync;
    logic          unused_clk_level, unused_data_level, unused_data_fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (clk),
        .rst   (rst),
        .raw   (ps2_clk_in),
        .sync  (clk_sync),
        .level (unused_clk_level),
        .fall  (fall)
    );

    ps2_line_filter #(.FILTER_LEN(1)) u_data_filter (
        .clk   (clk),
        .rst   (rst),
        .raw   (ps2_data_in),
        .sync  (data_sync),
        .level (unused_data_level),
        .fall  (unused_data_fall)
    );

    assign timed       = state == XFER || state == ACK || state == WAIT_IDLE;
    assign expire      = timed && tmo == TW'(TIMEOUT_CYCLES - 1);
    assign busy        = state != IDLE;
    assign ps2_clk_oe  = state == INHIBIT || state == REQ;
    assign ps2_data_oe = state == REQ || (state == XFER && !tx);

    // Next-state logic; timeout expiry overrides any coincident device clock edge
    always_comb begin
        nxt      = state;
        set_done = 1'b0;
        set_err  = 1'b0;
        if (expire) begin
            nxt     = IDLE;
            set_err = 1'b1;
        end else begin
            case (state)
                IDLE:      if (start && !done && !err) nxt = INHIBIT;
                INHIBIT:   if (ic == IW'(INHIBIT_CYCLES - 1)) nxt = REQ;
                REQ:       nxt = XFER;
                XFER:      if (fall && cnt == PARITY_BIT) nxt = ACK;
                ACK: begin
                    if (fall) begin
                        nxt     = data_sync ? IDLE : WAIT_IDLE;
                        set_err = data_sync;
                    end
                end
                WAIT_IDLE: begin
                    if (clk_sync && data_sync) begin
                        nxt      = IDLE;
                        set_done = 1'b1;
                    end
                end
                default:   nxt = IDLE;
            endcase
        end
    end

    // State, timers and frame shifter; tx holds the bit currently presented on the data line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ic    <= '0;
            tmo   <= '0;
            cnt   <= '0;
            sh    <= '0;
            tx    <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= nxt;
            done  <= set_done;
            err   <= set_err;
            ic    <= state == INHIBIT ? ic + 1'b1 : '0;
            tmo   <= (timed && !fall) ? tmo + 1'b1 : '0;
            if (state == IDLE && nxt == INHIBIT)
                sh <= {odd_parity(din), din};
            if (state == REQ) begin
                cnt <= '0;
                tx  <= 1'b0;
            end else if (state == XFER && fall) begin
                cnt <= cnt + 1'b1;
                tx  <= sh[0];
                sh  <= {1'b1, sh[8:1]};
            end
        end
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device transmitter for the PS/2 keyboard port, running on the 50 MHz system clock.
- Sends a command byte such as 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset) to the keyboard. It performs the request-to-send sequence, shifts data, parity and stop on device-generated clocks, and checks the device acknowledge.
- Drives the PS2KeyboardClk / PS2KeyboardData open-drain lines through output-enables. The top-level tristate ties them in.
- `busy` tells the existing keyboard receiver to ignore bus traffic while a transmission is in progress.

Parameters:
- INHIBIT_CYCLES, 5000: cycles clock is held low for request-to-send (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: max cycles between device clock falling edges (15 ms) before abort.
- FILTER_LEN, 8: cycles a synchronised PS/2 clock level must be stable before the filtered value changes.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to send `din`. Sampled only in IDLE.
- din  in  8  command byte, captured when `start` is accepted.
- busy  out  1  high from the cycle after accepted `start` until return to IDLE.
- done  out  1  one-cycle pulse: byte sent and acknowledged, bus idle.
- err  out  1  one-cycle pulse: NACK or timeout.
- ps2_clk_in  in  1  raw PS/2 clock line level.
- ps2_data_in  in  1  raw PS/2 data line level.
- ps2_clk_oe  out  1  1 = pull clock line low; 0 = release.
- ps2_data_oe  out  1  1 = pull data line low; 0 = release.

Behaviour:
- Reset (asynchronous, rst=0):
  - All outputs are 0, so both lines are released.
  - State is IDLE; counters and shift register are cleared.
  - Reset asserted mid-transfer releases both lines immediately.
- Input conditioning:
  - Both lines pass through a 2-FF synchroniser.
  - Clock is additionally filtered by FILTER_LEN.
  - `fall` is a one-cycle pulse on a filtered 1->0 transition.
  - Data is sampled as its synchronised value.
- IDLE:
  - Outputs low.
  - On start=1: latch din, compute parity = ~^din (odd parity), and go to INHIBIT.
  - `start` while busy is ignored.
- INHIBIT:
  - clk_oe=1 for exactly INHIBIT_CYCLES cycles.
  - Then go to REQ.
- REQ (1 cycle):
  - clk_oe=1 and data_oe=1 (start bit).
  - Next cycle: clk_oe=0 and go to XFER; bit counter = 0, timeout counter = 0.
- XFER: on each `fall`, the bit counter increments:
  - falls 1..8: data_oe = ~din[n-1] (LSB first);
  - fall 9: data_oe = ~parity;
  - fall 10: data_oe = 0 (stop bit), then go to ACK.
- ACK: on the next `fall`, sample data.
  - data=0: go to WAIT_IDLE.
  - data=1: err pulse, go to IDLE.
- WAIT_IDLE:
  - When synchronised clock=1 and data=1, pulse done for one cycle and go to IDLE.
- Timeout:
  - The timeout counter runs in XFER, ACK and WAIT_IDLE and resets on every `fall`.
  - Reaching TIMEOUT_CYCLES forces clk_oe=0 and data_oe=0, pulses err, and returns to IDLE.
- Pulses and overlap rules:
  - done and err are mutually exclusive and never asserted in the same cycle as start acceptance.
  - A fall coincident with timeout expiry: timeout wins.
- Width rules:
  - Bit counter is 4 bits; values above 10 are unreachable.
  - Timers are sized with $clog2 of their parameter.
- Latency:
  - start to busy: 1 cycle.
  - start to first data_oe: INHIBIT_CYCLES + 1 cycles.

Decomposition:
- Shared package ps2_pkg holds:
  - state encoding (IDLE, INHIBIT, REQ, XFER, ACK, WAIT_IDLE);
  - the bit-index constants for parity (9) and stop (10);
  - the odd-parity function.
  The package is reused by the receiver.
- Sub-module ps2_line_filter: synchroniser, FILTER_LEN stability filter and falling-edge pulse.
  - Instantiated once for the clock and once for data; the data instance uses FILTER_LEN=1.
  - Also reusable by the receiver.

Test Plan:
- Send 0xED with a device model clocking at 12 kHz and ACK low:
  - clk held low 5000 cycles; data low before clock release;
  - device samples 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - done pulses once; busy falls the same cycle.
- Send 0xF4: device samples 0,0,1,0,1,1,1,1, parity 0. Send 0x00: parity 1. Send 0xFF: parity 1.
- Device leaves data high at ACK -> err pulse, done never asserted, both oe=0, state IDLE.
- Device never clocks after REQ -> err exactly TIMEOUT_CYCLES cycles after REQ exit; lines released.
- Assert rst low during bit 4 -> clk_oe=0 and data_oe=0 with no clock edge required; a subsequent start with 0xFF completes normally.
- start pulsed during a transfer and 1 ns glitches on ps2_clk_in (shorter than FILTER_LEN) -> transfer byte unchanged, no extra bits, single done.
